sum_checker: RTL and testbench

SUM_CHECKER -- requirements
Module: sum_checker

---
 rtl/sum_checker.sv | 129 ++++++++++++
 tb/tb_sum_checker.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sum_checker.sv
// sum_checker: checks an upstream running sum against n*(n-1)/2 mod 2^W once i >= n.
// Optional watchdog enabled by defining SUM_CHECKER_TIMEOUT_EN.
module sum_checker #(
    parameter int W              = 19,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_in,
    input  logic [W-1:0] n_in,
    input  logic [W-1:0] c_in,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_sum,
    output logic         res_pass,
    output logic         res_timeout,
    output logic         busy,
    output logic         err_sticky
);
    typedef enum logic [1:0] {WAIT, MULT, REPORT, HOLD} state_t;
    localparam int CW = $clog2(W + 1);

    state_t         state_q, state_d;
    logic [W-1:0]   sum_q, sum_d, bound_q, bound_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           pass_q, pass_d, err_q, err_d;
    logic           done, expire;
    logic [W:0]     acc;

    assign done = i_in >= n_in;
    // Right-shifting shift-add: the low half holds the multiplier (n-1), the high half accumulates.
    assign acc  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, bound_q} : '0);

`ifdef SUM_CHECKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_q, wd_d;
    logic          to_q, to_d;

    assign expire      = state_q == WAIT && !done && wd_q == TW'(TIMEOUT_CYCLES - 1);
    assign res_timeout = to_q;

    always_comb begin
        wd_d = (state_q == WAIT && !done && !expire) ? wd_q + TW'(1) : '0;
        to_d = state_q == WAIT ? expire : to_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end
`else
    assign expire      = 1'b0;
    assign res_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        bound_d = bound_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        err_d   = err_q;
        case (state_q)
            WAIT: begin
                if (done) begin
                    state_d = MULT;
                    sum_d   = c_in;
                    bound_d = n_in;
                    prod_d  = {{W{1'b0}}, n_in - W'(1)};
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end else if (expire) begin
                    state_d = REPORT;
                    sum_d   = c_in;
                    pass_d  = 1'b0;
                end
            end
            MULT: begin
                if (cnt_q == CW'(W)) begin
                    state_d = REPORT;
                    pass_d  = sum_q == prod_q[W:1];
                end else begin
                    prod_d = {acc, prod_q[W-1:1]};
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            REPORT: begin
                if (res_ready) begin
                    state_d = HOLD;
                    err_d   = err_q | ~pass_q | res_timeout;
                end
            end
            HOLD: state_d = done ? HOLD : WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT;
            sum_q   <= '0;
            bound_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            bound_q <= bound_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
        end
    end

    assign res_valid  = state_q == REPORT;
    assign busy       = state_q == MULT || state_q == REPORT;
    assign res_sum    = sum_q;
    assign res_pass   = pass_q;
    assign err_sticky = err_q;
endmodule

// File: tb/tb_sum_checker.sv
// tb_sum_checker: directed self-checking bench for sum_checker.
module tb_sum_checker;
    localparam int W = 19;

    logic         clk = 1'b0, rst = 1'b1, res_ready = 1'b0;
    logic [W-1:0] i_in = '0, n_in = '0, c_in = '0;
    logic         res_valid, res_pass, res_timeout, busy, err_sticky;
    logic [W-1:0] res_sum;
    int           checks = 0, errors = 0, lat;

    always #5 clk = ~clk;

    sum_checker #(.W(W), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .rst(rst), .i_in(i_in), .n_in(n_in), .c_in(c_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_pass(res_pass), .res_timeout(res_timeout), .busy(busy),
        .err_sticky(err_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int max, output int l);
        l = 0;
        while (res_valid !== 1'b1 && l < max) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, res_valid, 0);
        chk({tag, "_sum"}, res_sum, 0);
        chk({tag, "_pass"}, res_pass, 0);
        chk({tag, "_timeout"}, res_timeout, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err_sticky, 0);
    endtask

    initial begin
        // reset, then n=0 / i=0 / c=0 completes immediately
        cyc(2);
        chk_zero("reset");
        rst = 1'b0;
        cyc(1);
        chk("n0_busy", busy, 1);
        wait_valid(100, lat);
        chk("n0_lat", lat, W + 1);
        chk("n0_sum", res_sum, 0);
        chk("n0_pass", res_pass, 1);
        chk("n0_timeout", res_timeout, 0);
        res_ready = 1'b1;
        cyc(1);
        chk("n0_hs_valid", res_valid, 0);
        res_ready = 1'b0;
        n_in = 150;
        i_in = 0;
        cyc(1);
        // counting run 0..150 with running sum
        for (int k = 0; k < 150; k++) begin
            i_in = W'(k);
            c_in = W'(k * (k - 1) / 2);
            cyc(1);
        end
        chk("count_idle", busy, 0);
        i_in = 150;
        c_in = 11175;
        cyc(1);
        chk("count_busy", busy, 1);
        chk("count_nvalid", res_valid, 0);
        wait_valid(100, lat);
        chk("count_lat", lat, W + 1);
        chk("count_sum", res_sum, 11175);
        chk("count_pass", res_pass, 1);
        chk("count_err", err_sticky, 0);
        // backpressure: result stays stable
        for (int j = 0; j < 5; j++) begin
            cyc(1);
            chk("stall_valid", res_valid, 1);
            chk("stall_sum", res_sum, 11175);
            chk("stall_pass", res_pass, 1);
        end
        res_ready = 1'b1;
        cyc(1);
        chk("hs_valid", res_valid, 0);
        chk("hs_busy", busy, 0);
        chk("hs_err", err_sticky, 0);
        cyc(3);
        chk("hold_busy", busy, 0);
        chk("hold_valid", res_valid, 0);
        res_ready = 1'b0;
        i_in = 0;
        cyc(1);
        // reset in the middle of MULT
        i_in = 150;
        c_in = 11175;
        cyc(1);
        cyc(4);
        chk("mult_busy", busy, 1);
        rst = 1'b1;
        i_in = 0;
        cyc(1);
        chk_zero("midrst");
        rst = 1'b0;
        cyc(40);
        chk("midrst_novalid", res_valid, 0);
        chk("midrst_nobusy", busy, 0);
        // bad sum sets err_sticky
        i_in = 150;
        c_in = 11174;
        cyc(1);
        wait_valid(100, lat);
        chk("bad_lat", lat, W + 1);
        chk("bad_sum", res_sum, 11174);
        chk("bad_pass", res_pass, 0);
        chk("bad_err_pre", err_sticky, 0);
        res_ready = 1'b1;
        cyc(1);
        chk("bad_err_post", err_sticky, 1);
        res_ready = 1'b0;
        i_in = 0;
        cyc(1);
        // wrap case n=2000
        n_in = 2000;
        i_in = 2000;
        c_in = 426136;
        cyc(1);
        wait_valid(100, lat);
        chk("wrap_sum", res_sum, 426136);
        chk("wrap_pass", res_pass, 1);
        res_ready = 1'b1;
        cyc(1);
        chk("wrap_err_held", err_sticky, 1);
        res_ready = 1'b0;
        i_in = 0;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        chk_zero("rst2");
        // stuck index: watchdog (if built) or no result
        n_in = 150;
        i_in = 3;
        c_in = 123;
        rst = 1'b0;
        wait_valid(1100, lat);
`ifdef SUM_CHECKER_TIMEOUT_EN
        chk("wd_valid", res_valid, 1);
        chk("wd_timeout", res_timeout, 1);
        chk("wd_pass", res_pass, 0);
        chk("wd_sum", res_sum, 123);
        res_ready = 1'b1;
        cyc(1);
        chk("wd_err", err_sticky, 1);
`else
        chk("nowd_valid", res_valid, 0);
        chk("nowd_timeout", res_timeout, 0);
        chk("nowd_busy", busy, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
